// File: rtl/ball_control_param_if.sv
// Ball engine bus: frame/serve/racket/screen inputs and ball/score/status outputs.
// master: the side that drives the game inputs (screen selector, players, video timing).
// slave : the ball engine itself.
interface ball_control_param_if;
  logic        end_of_frame;
  logic        serve;
  logic [9:0]  pos_of_player_1;
  logic [9:0]  pos_of_player_2;
  logic        screen_idle;
  logic        screen_single;
  logic        screen_multi;
  logic [3:0]  points_player_1;
  logic [3:0]  points_player_2;
  logic [10:0] x_pos_of_ball;
  logic [10:0] y_pos_of_ball;
  logic        hit_p1;
  logic        hit_p2;
  logic        game_over;
  logic        winner;

  modport master (
    output end_of_frame, serve, pos_of_player_1, pos_of_player_2,
           screen_idle, screen_single, screen_multi,
    input  points_player_1, points_player_2, x_pos_of_ball, y_pos_of_ball,
           hit_p1, hit_p2, game_over, winner
  );

  modport slave (
    input  end_of_frame, serve, pos_of_player_1, pos_of_player_2,
           screen_idle, screen_single, screen_multi,
    output points_player_1, points_player_2, x_pos_of_ball, y_pos_of_ball,
           hit_p1, hit_p2, game_over, winner
  );
endinterface

// File: rtl/ball_control_param.sv
// Pong ball engine: moves the ball once per frame, bounces off edges/rackets,
// scores misses and stops the game at WIN_POINTS.
// Ports:
//   clk65MHz - system clock
//   rst      - asynchronous active-high reset
//   bus      - ball_control_param_if.slave (frame pulse, serve, rackets, screen
//              mode in; ball position, scores, hit pulses, game_over/winner out)
module ball_control_param #(
  parameter int unsigned H_RES        = 1024,
  parameter int unsigned V_RES        = 768,
  parameter int unsigned BALL_SIZE    = 15,
  parameter int unsigned RACKET_H     = 80,
  parameter int unsigned X_P2_BOUNCE  = 100,
  parameter int unsigned X_P1_BOUNCE  = 923,
  parameter int unsigned STEP_Y       = 3,
  parameter int unsigned STEP_X_MIN   = 4,
  parameter int unsigned STEP_X_MAX   = 12,
  parameter int unsigned SCORE_FRAMES = 60,
  parameter int unsigned WIN_POINTS   = 10
) (
  input  logic               clk65MHz,
  input  logic               rst,
  ball_control_param_if.slave bus
);

  localparam int unsigned CNT_W = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;

  localparam logic [10:0]        XC       = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0]        YC       = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0]        Y_MAX    = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0]        X_HIT_P1 = 11'(X_P1_BOUNCE - BALL_SIZE);
  localparam logic [10:0]        X_HIT_P2 = 11'(X_P2_BOUNCE);
  localparam logic signed [11:0] Y_MAX_S  = 12'(V_RES - BALL_SIZE);
  localparam logic signed [11:0] BALL_S   = 12'(BALL_SIZE);
  localparam logic signed [11:0] RACKET_S = 12'(RACKET_H);
  localparam logic signed [11:0] XP1_S    = 12'(X_P1_BOUNCE);
  localparam logic signed [11:0] XP2_S    = 12'(X_P2_BOUNCE);
  localparam logic signed [11:0] STEP_Y_S = 12'(STEP_Y);
  localparam logic [7:0]         VX_MIN   = 8'(STEP_X_MIN);
  localparam logic [7:0]         VX_MAX   = 8'(STEP_X_MAX);
  localparam logic [3:0]         WIN_P    = 4'(WIN_POINTS);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCORE_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, START, FLY, SCORE, WIN} state_t;

  state_t           state;
  logic             dir_right;   // 1: moving toward player 1
  logic             dir_down;
  logic             serve_down;  // vertical direction of the next serve
  logic [7:0]       vx;
  logic [CNT_W-1:0] frame_cnt;

  logic signed [11:0] x_cur, y_cur, vx_s, x_nxt, y_nxt, p1_top, p2_top;
  logic               cross_p1, cross_p2, hit_ok_p1, hit_ok_p2;
  logic               single_mode, miss, force_idle;
  logic [7:0]         vx_up;

  // Candidate move for this frame and the racket tests against the current y
  always_comb begin
    x_cur       = $signed({1'b0, bus.x_pos_of_ball});
    y_cur       = $signed({1'b0, bus.y_pos_of_ball});
    vx_s        = $signed({4'b0000, vx});
    p1_top      = $signed({2'b00, bus.pos_of_player_1});
    p2_top      = $signed({2'b00, bus.pos_of_player_2});
    x_nxt       = dir_right ? (x_cur + vx_s) : (x_cur - vx_s);
    y_nxt       = dir_down ? (y_cur + STEP_Y_S) : (y_cur - STEP_Y_S);
    cross_p1    = dir_right && ((x_nxt + BALL_S) > XP1_S);
    cross_p2    = !dir_right && (x_nxt < XP2_S);
    hit_ok_p1   = ((y_cur + BALL_S) >= p1_top) && (y_cur <= (p1_top + RACKET_S));
    hit_ok_p2   = ((y_cur + BALL_S) >= p2_top) && (y_cur <= (p2_top + RACKET_S));
    single_mode = bus.screen_single;
    miss        = (cross_p1 && !hit_ok_p1) || (cross_p2 && !single_mode && !hit_ok_p2);
    vx_up       = (vx >= VX_MAX) ? VX_MAX : (vx + 8'd1);
    force_idle  = bus.screen_idle || !(bus.screen_single || bus.screen_multi);
  end

  // Game FSM with registered outputs
  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      bus.x_pos_of_ball   <= XC;
      bus.y_pos_of_ball   <= YC;
      bus.points_player_1 <= 4'd0;
      bus.points_player_2 <= 4'd0;
      bus.hit_p1          <= 1'b0;
      bus.hit_p2          <= 1'b0;
      bus.game_over       <= 1'b0;
      bus.winner          <= 1'b0;
      vx                  <= VX_MIN;
      dir_right           <= 1'b1;
      dir_down            <= 1'b1;
      serve_down          <= 1'b1;
      frame_cnt           <= '0;
    end else begin
      bus.hit_p1 <= 1'b0;
      bus.hit_p2 <= 1'b0;
      if (force_idle) begin
        state               <= IDLE;
        bus.x_pos_of_ball   <= XC;
        bus.y_pos_of_ball   <= YC;
        bus.points_player_1 <= 4'd0;
        bus.points_player_2 <= 4'd0;
        bus.game_over       <= 1'b0;
        vx                  <= VX_MIN;
        dir_right           <= 1'b1;
        dir_down            <= 1'b1;
        serve_down          <= 1'b1;
      end else begin
        unique case (state)
          IDLE: state <= START;

          START: begin
            bus.x_pos_of_ball <= XC;
            bus.y_pos_of_ball <= YC;
            vx                <= VX_MIN;
            if (bus.serve) begin
              state      <= FLY;
              dir_down   <= serve_down;
              serve_down <= ~serve_down;
            end
          end

          FLY: if (bus.end_of_frame) begin
            if (miss) begin
              // Ball freezes in place; next serve heads toward the conceding player
              state     <= SCORE;
              frame_cnt <= '0;
              if (cross_p1) begin
                dir_right <= 1'b1;
                if (bus.points_player_2 < WIN_P) bus.points_player_2 <= bus.points_player_2 + 4'd1;
              end else begin
                dir_right <= 1'b0;
                if (bus.points_player_1 < WIN_P) bus.points_player_1 <= bus.points_player_1 + 4'd1;
              end
            end else begin
              if (y_nxt <= 12'sd0) begin
                bus.y_pos_of_ball <= 11'd0;
                dir_down          <= 1'b1;
              end else if (y_nxt >= Y_MAX_S) begin
                bus.y_pos_of_ball <= Y_MAX;
                dir_down          <= 1'b0;
              end else begin
                bus.y_pos_of_ball <= y_nxt[10:0];
              end
              if (cross_p1) begin
                bus.x_pos_of_ball <= X_HIT_P1;
                dir_right         <= 1'b0;
                bus.hit_p1        <= 1'b1;
                vx                <= vx_up;
              end else if (cross_p2) begin
                // Single-player wall reflects without speeding up
                bus.x_pos_of_ball <= X_HIT_P2;
                dir_right         <= 1'b1;
                bus.hit_p2        <= 1'b1;
                if (!single_mode) vx <= vx_up;
              end else begin
                bus.x_pos_of_ball <= x_nxt[10:0];
              end
            end
          end

          SCORE: if (bus.end_of_frame) begin
            if (frame_cnt == CNT_LAST) begin
              bus.x_pos_of_ball <= XC;
              bus.y_pos_of_ball <= YC;
              if ((bus.points_player_1 == WIN_P) || (bus.points_player_2 == WIN_P)) begin
                state         <= WIN;
                bus.game_over <= 1'b1;
                bus.winner    <= (bus.points_player_2 == WIN_P);
              end else begin
                state <= START;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end

          WIN: begin
            bus.x_pos_of_ball <= XC;
            bus.y_pos_of_ball <= YC;
            if (bus.serve) begin
              bus.points_player_1 <= 4'd0;
              bus.points_player_2 <= 4'd0;
              bus.game_over       <= 1'b0;
              state               <= START;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_control_param.sv
// Randomized bench for ball_control_param against a frame-level game model.
module tb_ball_control_param;

  localparam int H_RES = 1024, V_RES = 768, BALL = 15, RACKET_H = 80;
  localparam int XP2 = 100, XP1 = 923, STEP_Y = 3, VMIN = 4, VMAX = 12;
  localparam int SCORE_FRAMES = 60, WIN_POINTS = 2;
  localparam int XC = (H_RES - BALL) / 2, YC = (V_RES - BALL) / 2;
  localparam int YMAX = V_RES - BALL;

  logic clk65MHz = 1'b0;
  logic rst;
  ball_control_param_if bus();

  ball_control_param #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL), .RACKET_H(RACKET_H),
    .X_P2_BOUNCE(XP2), .X_P1_BOUNCE(XP1), .STEP_Y(STEP_Y),
    .STEP_X_MIN(VMIN), .STEP_X_MAX(VMAX),
    .SCORE_FRAMES(SCORE_FRAMES), .WIN_POINTS(WIN_POINTS)
  ) dut (
    .clk65MHz(clk65MHz),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk65MHz = ~clk65MHz;

  typedef enum int {M_IDLE, M_START, M_FLY, M_SCORE, M_WIN} mstate_t;

  // Game model: signed velocities, plain integers
  mstate_t m_st;
  int mx, my, mvx, mvy, m_serve_vy, mp1, mp2, mh1, mh2, mgo, mwin, mcnt;
  int n_checks = 0, n_pass = 0, cyc = 0, hit_rate = 85;

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    if (obs != exp) $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  task automatic compare_all(string tag);
    check({tag, ":x"}, int'(bus.x_pos_of_ball), mx);
    check({tag, ":y"}, int'(bus.y_pos_of_ball), my);
    check({tag, ":p1"}, int'(bus.points_player_1), mp1);
    check({tag, ":p2"}, int'(bus.points_player_2), mp2);
    check({tag, ":hit1"}, int'(bus.hit_p1), mh1);
    check({tag, ":hit2"}, int'(bus.hit_p2), mh2);
    check({tag, ":game_over"}, int'(bus.game_over), mgo);
    if (mgo != 0) check({tag, ":winner"}, int'(bus.winner), mwin);
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; mx = XC; my = YC; mp1 = 0; mp2 = 0; mh1 = 0; mh2 = 0;
    mgo = 0; mwin = 0; mvx = VMIN; mvy = STEP_Y; m_serve_vy = STEP_Y; mcnt = 0;
  endtask

  // One clock of the game rules, using the inputs present at the edge
  task automatic model_edge();
    int nx, ny, p1, p2;
    bit miss;
    mh1 = 0; mh2 = 0;
    if (bus.screen_idle || !(bus.screen_single || bus.screen_multi)) begin
      m_st = M_IDLE; mx = XC; my = YC; mp1 = 0; mp2 = 0; mgo = 0;
      mvx = VMIN; mvy = STEP_Y; m_serve_vy = STEP_Y;
      return;
    end
    p1 = int'(bus.pos_of_player_1);
    p2 = int'(bus.pos_of_player_2);
    case (m_st)
      M_IDLE: m_st = M_START;
      M_START: begin
        mx = XC; my = YC;
        mvx = (mvx > 0) ? VMIN : -VMIN;
        if (bus.serve) begin
          m_st = M_FLY; mvy = m_serve_vy; m_serve_vy = -m_serve_vy;
        end
      end
      M_FLY: if (bus.end_of_frame) begin
        nx = mx + mvx; ny = my + mvy; miss = 0;
        if (mvx > 0 && nx + BALL > XP1) begin
          if (my + BALL >= p1 && my <= p1 + RACKET_H) begin
            nx = XP1 - BALL; mvx = -imin(mvx + 1, VMAX); mh1 = 1;
          end else begin
            miss = 1; if (mp2 < WIN_POINTS) mp2++;
          end
        end else if (mvx < 0 && nx < XP2) begin
          if (bus.screen_single) begin
            nx = XP2; mvx = -mvx; mh2 = 1;
          end else if (my + BALL >= p2 && my <= p2 + RACKET_H) begin
            nx = XP2; mvx = imin(-mvx + 1, VMAX); mh2 = 1;
          end else begin
            miss = 1; if (mp1 < WIN_POINTS) mp1++;
          end
        end
        if (miss) begin
          m_st = M_SCORE; mcnt = 0;
        end else begin
          if (ny <= 0) begin ny = 0; mvy = STEP_Y; end
          else if (ny >= YMAX) begin ny = YMAX; mvy = -STEP_Y; end
          mx = nx; my = ny;
        end
      end
      M_SCORE: if (bus.end_of_frame) begin
        mcnt++;
        if (mcnt == SCORE_FRAMES) begin
          mx = XC; my = YC;
          if (mp1 == WIN_POINTS || mp2 == WIN_POINTS) begin
            m_st = M_WIN; mgo = 1; mwin = (mp2 == WIN_POINTS) ? 1 : 0;
          end else m_st = M_START;
        end
      end
      M_WIN: if (bus.serve) begin
        mp1 = 0; mp2 = 0; mgo = 0; m_st = M_START;
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic tick(bit eof);
    @(negedge clk65MHz);
    bus.end_of_frame = eof;
    @(posedge clk65MHz);
    if (rst) model_reset(); else model_edge();
    #1;
    cyc++;
    compare_all("cyc");
  endtask

  // Rackets either cover the ball's current y or sit far from it
  function automatic int racket_for(bit hit);
    int p;
    if (hit) begin
      p = my + BALL - int'($urandom_range(0, BALL + RACKET_H));
      if (p < 0) p = 0;
      if (p > V_RES - RACKET_H) p = V_RES - RACKET_H;
    end else p = (my > 384) ? 0 : 600;
    return p;
  endfunction

  task automatic run_frame();
    int gap;
    bus.pos_of_player_1 = 10'(racket_for(int'($urandom_range(0, 99)) < hit_rate));
    bus.pos_of_player_2 = 10'(racket_for(int'($urandom_range(0, 99)) < hit_rate));
    gap = int'($urandom_range(2, 4));
    tick(1'b1);
    for (int i = 1; i < gap; i++) tick(1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk65MHz);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_async:x", int'(bus.x_pos_of_ball), 504);
    check("rst_async:y", int'(bus.y_pos_of_ball), 376);
    compare_all("rst_async");
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int sel, nfr;
    rst = 1'b1;
    bus.end_of_frame = 1'b0; bus.serve = 1'b0;
    bus.pos_of_player_1 = 10'd360; bus.pos_of_player_2 = 10'd360;
    bus.screen_idle = 1'b0; bus.screen_single = 1'b0; bus.screen_multi = 1'b0;
    model_reset();
    tick(1'b0);
    tick(1'b0);
    check("reset:x", int'(bus.x_pos_of_ball), 504);
    check("reset:y", int'(bus.y_pos_of_ball), 376);
    rst = 1'b0;

    // First serve: coincident frame pulse must not move the ball
    bus.screen_multi = 1'b1;
    tick(1'b0);
    bus.serve = 1'b1;
    tick(1'b1);
    check("serve_no_move:x", int'(bus.x_pos_of_ball), 504);
    bus.serve = 1'b0;
    tick(1'b1);
    check("first_move:x", int'(bus.x_pos_of_ball), 508);
    check("first_move:y", int'(bus.y_pos_of_ball), 379);
    for (int f = 0; f < 20; f++) run_frame();
    async_reset();

    // Randomized play across screen modes
    for (int ph = 0; ph < 30; ph++) begin
      sel = int'($urandom_range(0, 99));
      nfr = int'($urandom_range(20, 400));
      hit_rate = int'($urandom_range(70, 100));
      bus.screen_idle   = (sel >= 88 && sel < 94);
      bus.screen_single = (sel >= 45 && sel < 88);
      bus.screen_multi  = (sel < 45) || (sel >= 80 && sel < 94);
      for (int f = 0; f < nfr; f++) begin
        bus.serve = (int'($urandom_range(0, 99)) < 30);
        if ($urandom_range(0, 999) == 0) async_reset();
        run_frame();
      end
    end

    // Player 2 wins by two right-side misses
    async_reset();
    hit_rate = 0;
    bus.screen_idle = 1'b0; bus.screen_single = 1'b0; bus.screen_multi = 1'b1;
    bus.serve = 1'b0;
    for (int f = 0; f < 800 && mgo == 0; f++) begin
      bus.serve = (m_st == M_START);
      run_frame();
    end
    bus.serve = 1'b0;
    check("win:game_over", int'(bus.game_over), 1);
    check("win:winner", int'(bus.winner), 1);
    check("win:p2", int'(bus.points_player_2), 2);
    bus.serve = 1'b1;
    tick(1'b0);
    check("restart:p2", int'(bus.points_player_2), 0);
    check("restart:game_over", int'(bus.game_over), 0);
    bus.serve = 1'b0;
    tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
